// File: rtl/pipe_out_arbiter_if.sv
// Source-FIFO and pipe-out endpoint signals shared between the arbiter and its
// neighbours. The master side is the arbiter.
interface pipe_out_arbiter_if #(
   parameter int N_SRC = 4,
   parameter int CNT_W = 11
);
   logic [N_SRC-1:0]       src_en;
   logic [N_SRC*CNT_W-1:0] src_count;
   logic [N_SRC*16-1:0]    src_data;
   logic [N_SRC-1:0]       src_rd;
   logic                   pipe_out_read;
   logic [15:0]            pipe_out_data;
   logic                   pipe_out_valid;

   modport master (
      input  src_en, src_count, src_data, pipe_out_read,
      output src_rd, pipe_out_data, pipe_out_valid
   );

   modport slave (
      output src_en, src_count, src_data, pipe_out_read,
      input  src_rd, pipe_out_data, pipe_out_valid
   );
endinterface

// File: rtl/pipe_out_arbiter.sv
// Round-robin, block-throttled scheduler sharing one 16-bit pipe-out endpoint
// between N_SRC FWFT source FIFOs; one full block is transferred per grant.
module pipe_out_arbiter_lane #(
   parameter int          CNT_W       = 11,
   parameter int          BLOCK_WORDS = 256,
   parameter logic [2:0]  IDX         = 3'd0
) (
   input  logic             en,
   input  logic [CNT_W-1:0] count,
   input  logic [15:0]      data,
   input  logic [2:0]       grant_id,
   input  logic             xfer,
   input  logic             read,
   output logic             elig,
   output logic             rd,
   output logic             uflow,
   output logic [15:0]      data_sel
);
   logic sel;

   assign sel      = xfer && (grant_id == IDX);
   assign elig     = en && (count >= CNT_W'(BLOCK_WORDS));
   assign rd       = sel && read;
   // The read is still forwarded on an empty FIFO; only the fault is recorded.
   assign uflow    = sel && read && (count == '0);
   assign data_sel = sel ? data : 16'h0000;
endmodule

module pipe_out_arbiter #(
   parameter int N_SRC       = 4,
   parameter int BLOCK_WORDS = 256,
   parameter int CNT_W       = 11
) (
   input  logic              clk,
   input  logic              reset,
   pipe_out_arbiter_if.master bus,
   output logic [2:0]        grant_id,
   output logic              busy,
   output logic [15:0]       blocks_sent,
   output logic [15:0]       err_flags
);
   localparam int WC_W = $clog2(BLOCK_WORDS) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]            state;
   logic [2:0]            last_grant;
   logic [WC_W-1:0]       word_cnt;
   logic [1:0]            err;
   logic                  xfer;
   logic                  last_word;
   logic                  found;
   logic [2:0]            next_idx;
   logic [7:0]            elig8;
   logic [N_SRC-1:0]      elig;
   logic [N_SRC-1:0]      uflow;
   logic [N_SRC-1:0][15:0] lane_data;
   logic [15:0]           data_or;

   assign xfer = (state == S_XFER);

   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_lane
         pipe_out_arbiter_lane #(
            .CNT_W      (CNT_W),
            .BLOCK_WORDS(BLOCK_WORDS),
            .IDX        (3'(gi))
         ) u_lane (
            .en      (bus.src_en[gi]),
            .count   (bus.src_count[gi*CNT_W +: CNT_W]),
            .data    (bus.src_data[gi*16 +: 16]),
            .grant_id(grant_id),
            .xfer    (xfer),
            .read    (bus.pipe_out_read),
            .elig    (elig[gi]),
            .rd      (bus.src_rd[gi]),
            .uflow   (uflow[gi]),
            .data_sel(lane_data[gi])
         );
      end
   endgenerate

   // Non-selected lanes present zero, so the mux reduces to an OR.
   always_comb begin
      data_or = 16'h0000;
      for (int i = 0; i < N_SRC; i++) data_or = data_or | lane_data[i];
   end

   assign bus.pipe_out_data  = data_or;
   assign bus.pipe_out_valid = xfer;
   assign busy               = xfer;
   assign err_flags          = {14'h0000, err};

   // Padded to 8 so a 3-bit index covers every legal N_SRC.
   assign elig8 = 8'(elig);

   always_comb begin
      int cand;
      cand     = 0;
      found    = 1'b0;
      next_idx = 3'd0;
      for (int off = 1; off <= N_SRC; off++) begin
         cand = int'(last_grant) + off;
         if (cand >= N_SRC) cand = cand - N_SRC;
         if (!found && elig8[3'(cand)]) begin
            found    = 1'b1;
            next_idx = 3'(cand);
         end
      end
   end

   assign last_word = xfer && bus.pipe_out_read &&
                      (word_cnt == WC_W'(BLOCK_WORDS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         last_grant  <= 3'(N_SRC - 1);
         grant_id    <= 3'd0;
         word_cnt    <= '0;
         blocks_sent <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant_id <= next_idx;
                  state    <= S_XFER;
               end
            end
            S_XFER: begin
               if (last_word) begin
                  word_cnt    <= '0;
                  blocks_sent <= blocks_sent + 16'd1;
                  last_grant  <= grant_id;
                  state       <= S_GAP;
               end else if (bus.pipe_out_read) begin
                  word_cnt <= word_cnt + WC_W'(1);
               end
            end
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 2'b00;
      end else begin
         if (bus.pipe_out_read && !xfer) err[0] <= 1'b1;
         if (|uflow)                     err[1] <= 1'b1;
      end
   end
endmodule

// File: doc/pipe_out_arbiter.md
# pipe_out_arbiter

Block-throttled scheduler that shares one 16-bit block-throttled pipe-out endpoint between N_SRC first-word-fall-through source FIFOs. It selects sources round-robin, only grants a source holding at least one full block, and asserts the endpoint's ready for exactly one block per grant. Read strobes are steered to the granted FIFO, and its data is muxed onto the endpoint. It runs in the host-interface clock domain, between the per-source FIFOs and the pipe-out endpoint, and exposes sticky error/status words for wire-outs.

## Interface
- N_SRC, 4: number of sources, 2..8.
- BLOCK_WORDS, 256: 16-bit words per host block, power of two, 2..1024.
- CNT_W, 11: width of each source fill count; must hold BLOCK_WORDS.
- clk  in  1  host-interface clock (ti_clk).
- reset  in  1  asynchronous, active-high reset.
- src_en  in  N_SRC  per-source enable (wire-in); disabled sources are never granted.
- src_count  in  N_SRC*CNT_W  FIFO fill level, source i at [i*CNT_W +: CNT_W].
- src_data  in  N_SRC*16  FWFT FIFO head word, source i at [i*16 +: 16].
- src_rd  out  N_SRC  one-hot FIFO read strobe.
- pipe_out_read  in  1  endpoint read strobe.
- pipe_out_data  out  16  word to the endpoint.
- pipe_out_valid  out  1  endpoint block-ready.
- grant_id  out  3  index of the current/last granted source.
- busy  out  1  high in XFER.
- blocks_sent  out  16  total completed blocks; wraps modulo 2^16.
- err_flags  out  16  sticky errors: bit0 read outside XFER, bit1 granted FIFO underflow; bits 15:2 are 0.

## Operation
- States:
  - IDLE: scan the sources for an eligible one.
  - XFER: one block in flight.
  - GAP: a single-cycle gap between blocks.
- A source is eligible when src_en[i]=1 and src_count[i] >= BLOCK_WORDS.
- IDLE:
  - Round-robin search starts at (last_grant+1) mod N_SRC.
  - The first eligible source found is registered into grant_id, and the state moves to XFER.
  - If no source is eligible, stay in IDLE.
- XFER:
  - pipe_out_valid=1.
  - src_rd[grant_id] = pipe_out_read, combinationally in the same cycle.
  - pipe_out_data = src_data[grant_id].
  - Each read increments word_cnt.
  - On the read that makes word_cnt equal BLOCK_WORDS: word_cnt clears, blocks_sent increments, last_grant is set to grant_id, and the next state is GAP.
- GAP: pipe_out_valid=0 for one cycle, then IDLE.
- Outside XFER: pipe_out_data=16'h0000 and src_rd=0.
- A pipe_out_read outside XFER sets err_flags[0] and is otherwise ignored.
- In XFER, a pipe_out_read while src_count[grant_id]==0 sets err_flags[1]. src_rd is still forwarded; protection against this is the FIFO's job.
- Clearing src_en of the granted source mid-block does not abort the block. Grants change only at block boundaries.
- err_flags clear only on reset.
- Reset values:
  - state=IDLE.
  - last_grant=N_SRC-1, so the first search starts at source 0.
  - grant_id=0, word_cnt=0, blocks_sent=0, err_flags=0.
  - All outputs 0.
- Reset mid-block abandons the block immediately; pipe_out_valid drops asynchronously. Recovering the host transfer is the host's job.

## Timing
- All state is on the rising edge of clk; reset is asynchronous.
- Grant latency: an eligible source seen in IDLE at edge k gives pipe_out_valid=1 after edge k. That is 1 cycle.
- pipe_out_valid stays high continuously from grant until the cycle of the final read, inclusive. It is low during the GAP cycle.
- Minimum spacing between blocks from the same or a different source is 2 cycles: GAP then IDLE.
- Read-to-data: zero cycles. The FWFT head is presented combinationally, and src_rd advances the FIFO at the same edge that the endpoint samples the data.
- Back-to-back reads on every cycle are supported; gaps between reads are allowed.
- word_cnt width is clog2(BLOCK_WORDS)+1. No wrap occurs inside a block.

## Test plan
- Single source: src_en=4'b0001, src_count[0]=256, FIFO holds 0..255, host reads 256 words.
  - Required: pipe_out_data 0..255 in order, src_rd[0] pulses 256 times, pipe_out_valid low on the next cycle, blocks_sent=1, err_flags=0.
- Round-robin: all four sources enabled, each with 512 words tagged with the source id in bits 15:12, host reads 8 blocks.
  - Required: grant order 0,1,2,3,0,1,2,3 and blocks_sent=8.
- Threshold: src_count[2]=255, src_en=4'b0100.
  - Required: pipe_out_valid stays 0 for 100 cycles.
  - Raising the count to 256 gives pipe_out_valid=1 exactly 1 cycle later, with grant_id=2.
- Disable mid-block: src_en[1] cleared after 100 of 256 reads.
  - Required: the block completes from source 1, and source 1 is not granted again.
- Errors:
  - A pipe_out_read pulse in IDLE gives err_flags=16'h0001 and src_rd=0.
  - A read in XFER with src_count=0 also sets bit1.
  - Both bits persist until reset.
- Reset after 50 reads of a block.
  - Required: pipe_out_valid=0 and grant_id=0 immediately, and blocks_sent=0.
  - With all sources eligible, the first post-reset grant is source 0.
